data_mem_controller: RTL and testbench

- Sits directly downstream of the per-thread LSUs. Arbitrates their read and write requests onto one external data-memory channel and returns the responses.
- Serves NUM_CONSUMERS request ports, one per LSU, in round-robin order.
- Keeps one memory transaction outstanding at a time.
- Each side uses a level valid / one-cycle ready handshake: the requester holds valid until it sees ready=1, then drops valid.

---
 rtl/data_mem_controller_pkg.sv | 22 ++
 rtl/data_mem_controller_rr_arbiter.sv | 29 ++
 rtl/data_mem_controller.sv | 150 +++++++++++++++
 tb/tb_data_mem_controller.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_controller_pkg.sv
// Shared types and sizing helpers for the LSU-side data-memory controller.
package data_mem_controller_pkg;

  localparam int unsigned DMC_ADDR_BITS = 8;
  localparam int unsigned DMC_DATA_BITS = 32;

  typedef logic [DMC_DATA_BITS-1:0] data_t;
  typedef logic [DMC_ADDR_BITS-1:0] data_memory_address_t;

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    READ_WAITING  = 2'd1,
    WRITE_WAITING = 2'd2,
    RELAXING      = 2'd3
  } mem_ctrl_state_t;

  // Index width for a port count; a single port still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_mem_controller_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
module data_mem_controller_rr_arbiter
  import data_mem_controller_pkg::*;
#(
  parameter int unsigned NUM_CONSUMERS = 8,
  parameter int unsigned IDX_W         = idx_width(NUM_CONSUMERS)
) (
  input  logic [NUM_CONSUMERS-1:0] req_i,
  input  logic [IDX_W-1:0]         ptr_i,
  output logic                     grant_valid_o,
  output logic [IDX_W-1:0]         grant_index_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_valid_o = 1'b0;
    grant_index_o = '0;
    cand          = '0;
    for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
      cand = IDX_W'((32'(ptr_i) + k) % NUM_CONSUMERS);
      if (!grant_valid_o && req_i[cand]) begin
        grant_valid_o = 1'b1;
        grant_index_o = cand;
      end
    end
  end

endmodule

// File: rtl/data_mem_controller.sv
// Round-robin arbiter of per-LSU read/write requests onto a single data-memory
// channel, one outstanding transaction at a time, with registered outputs.
module data_mem_controller
  import data_mem_controller_pkg::*;
#(
  parameter int unsigned NUM_CONSUMERS = 8,
  parameter int unsigned ADDR_BITS     = DMC_ADDR_BITS,
  parameter int unsigned DATA_BITS     = DMC_DATA_BITS
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready
);

  localparam int unsigned     IDX_W    = idx_width(NUM_CONSUMERS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CONSUMERS - 1);

  mem_ctrl_state_t          state_q;
  logic [IDX_W-1:0]         cur_q;
  logic [IDX_W-1:0]         rr_ptr_q;
  logic                     served_rd_q;
  logic                     mem_read_valid_q;
  logic [ADDR_BITS-1:0]     mem_read_address_q;
  logic                     mem_write_valid_q;
  logic [ADDR_BITS-1:0]     mem_write_address_q;
  logic [DATA_BITS-1:0]     mem_write_data_q;
  logic [NUM_CONSUMERS-1:0] read_ready_q;
  logic [NUM_CONSUMERS-1:0] write_ready_q;
  logic [DATA_BITS-1:0]     read_data_q [NUM_CONSUMERS];

  logic [ADDR_BITS-1:0]     rd_addr_arr [NUM_CONSUMERS];
  logic [ADDR_BITS-1:0]     wr_addr_arr [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     wr_data_arr [NUM_CONSUMERS];

  logic                     grant_valid;
  logic [IDX_W-1:0]         grant_idx;
  logic                     served_valid;
  logic [IDX_W-1:0]         rr_ptr_d;

  // Unpack flat per-consumer buses and repack the registered read data.
  for (genvar g = 0; g < NUM_CONSUMERS; g++) begin : g_lanes
    assign rd_addr_arr[g] = consumer_read_address[g*ADDR_BITS +: ADDR_BITS];
    assign wr_addr_arr[g] = consumer_write_address[g*ADDR_BITS +: ADDR_BITS];
    assign wr_data_arr[g] = consumer_write_data[g*DATA_BITS +: DATA_BITS];
    assign consumer_read_data[g*DATA_BITS +: DATA_BITS] = read_data_q[g];
  end

  data_mem_controller_rr_arbiter #(
    .NUM_CONSUMERS (NUM_CONSUMERS),
    .IDX_W         (IDX_W)
  ) u_rr_arbiter (
    .req_i         (consumer_read_valid | consumer_write_valid),
    .ptr_i         (rr_ptr_q),
    .grant_valid_o (grant_valid),
    .grant_index_o (grant_idx)
  );

  // The LSU must drop the valid we just served before we re-arbitrate.
  assign served_valid = served_rd_q ? consumer_read_valid[cur_q]
                                    : consumer_write_valid[cur_q];
  assign rr_ptr_d     = (cur_q == LAST_IDX) ? '0 : cur_q + IDX_W'(1);

  assign consumer_read_ready  = read_ready_q;
  assign consumer_write_ready = write_ready_q;
  assign mem_read_valid       = mem_read_valid_q;
  assign mem_read_address     = mem_read_address_q;
  assign mem_write_valid      = mem_write_valid_q;
  assign mem_write_address    = mem_write_address_q;
  assign mem_write_data       = mem_write_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= IDLE;
      cur_q               <= '0;
      rr_ptr_q            <= '0;
      served_rd_q         <= 1'b0;
      mem_read_valid_q    <= 1'b0;
      mem_read_address_q  <= '0;
      mem_write_valid_q   <= 1'b0;
      mem_write_address_q <= '0;
      mem_write_data_q    <= '0;
      read_ready_q        <= '0;
      write_ready_q       <= '0;
      for (int i = 0; i < int'(NUM_CONSUMERS); i++) begin
        read_data_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            cur_q <= grant_idx;
            // A consumer with both requests pending gets its read first.
            if (consumer_read_valid[grant_idx]) begin
              served_rd_q        <= 1'b1;
              mem_read_valid_q   <= 1'b1;
              mem_read_address_q <= rd_addr_arr[grant_idx];
              state_q            <= READ_WAITING;
            end else begin
              served_rd_q         <= 1'b0;
              mem_write_valid_q   <= 1'b1;
              mem_write_address_q <= wr_addr_arr[grant_idx];
              mem_write_data_q    <= wr_data_arr[grant_idx];
              state_q             <= WRITE_WAITING;
            end
          end
        end
        READ_WAITING: begin
          if (mem_read_ready) begin
            mem_read_valid_q    <= 1'b0;
            read_data_q[cur_q]  <= mem_read_data;
            read_ready_q[cur_q] <= 1'b1;
            state_q             <= RELAXING;
          end
        end
        WRITE_WAITING: begin
          if (mem_write_ready) begin
            mem_write_valid_q    <= 1'b0;
            write_ready_q[cur_q] <= 1'b1;
            state_q              <= RELAXING;
          end
        end
        RELAXING: begin
          if (!served_valid) begin
            read_ready_q[cur_q]  <= 1'b0;
            write_ready_q[cur_q] <= 1'b0;
            rr_ptr_q             <= rr_ptr_d;
            state_q              <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_controller.sv
// Directed bench for data_mem_controller with a transaction-level round-robin
// model, a behavioural memory responder and LSU stand-ins.
module tb_data_mem_controller;

  localparam int N   = 8;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int RAW = N * AW;
  localparam int RDW = N * DW;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   crv, crr, cwv, cwr;
  logic [RAW-1:0] cra, cwa;
  logic [RDW-1:0] crd, cwd;
  logic           mrv, mrr, mwv, mwr;
  logic [AW-1:0]  mra, mwa;
  logic [DW-1:0]  mrd, mwd;

  always #5 clk = ~clk;

  data_mem_controller #(.NUM_CONSUMERS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (crv),
    .consumer_read_address  (cra),
    .consumer_read_ready    (crr),
    .consumer_read_data     (crd),
    .consumer_write_valid   (cwv),
    .consumer_write_address (cwa),
    .consumer_write_data    (cwd),
    .consumer_write_ready   (cwr),
    .mem_read_valid         (mrv),
    .mem_read_address       (mra),
    .mem_read_ready         (mrr),
    .mem_read_data          (mrd),
    .mem_write_valid        (mwv),
    .mem_write_address      (mwa),
    .mem_write_data         (mwd),
    .mem_write_ready        (mwr)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem_model [256];
  int  lat = 3;
  bit  mem_auto = 1'b1;
  int  rd_cnt, wr_cnt;
  int  hold [N];

  bit            m_busy;
  int            m_cur, m_ptr;
  bit            m_rd;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;
  logic [DW-1:0] exp_rdata [N];
  int            done_q [$];
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wd;
  bit            rd_seen;

  logic [N-1:0] p_rv, p_wv, p_crr, p_cwr;
  logic         p_mrv, p_mwv, p_mrr, p_mwr, p_rst;

  task automatic cmp(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    return N'(1) << i;
  endfunction

  function automatic logic [AW-1:0] raddr(input int i);
    return AW'(cra >> (i * AW));
  endfunction

  function automatic logic [AW-1:0] waddr(input int i);
    return AW'(cwa >> (i * AW));
  endfunction

  function automatic logic [DW-1:0] wdata(input int i);
    return DW'(cwd >> (i * DW));
  endfunction

  function automatic int get_done(input int k);
    return (k < done_q.size()) ? done_q[k] : -1;
  endfunction

  task automatic set_read(input int i, input logic [AW-1:0] a);
    cra = (cra & ~(RAW'(8'hFF) << (i * AW))) | (RAW'(a) << (i * AW));
    crv = crv | oh(i);
  endtask

  task automatic set_write(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cwa = (cwa & ~(RAW'(8'hFF) << (i * AW))) | (RAW'(a) << (i * AW));
    cwd = (cwd & ~(RDW'(32'hFFFF_FFFF) << (i * DW))) | (RDW'(d) << (i * DW));
    cwv = cwv | oh(i);
  endtask

  // Model: round-robin grant prediction, completion tracking, read-data hold.
  task automatic check();
    logic [N-1:0]   er, ew, oh_cur;
    logic [RDW-1:0] pk;
    int             w;
    if (p_rst) begin
      m_busy = 1'b0; m_ptr = 0; m_cur = 0; rd_cnt = 0; wr_cnt = 0;
      for (int k = 0; k < N; k++) exp_rdata[k] = '0;
      cmp("reset_outputs", {crr, cwr, mrv, mwv, mra, mwa, mwd}, '0);
      cmp("reset_rdata", crd, '0);
    end else begin
      if (mrv) rd_seen = 1'b1;
      cmp("mem_exclusive", mrv & mwv, 0);
      if ((mrv && !p_mrv) || (mwv && !p_mwv)) begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (w < 0 && ((p_rv | p_wv) & oh(c)) != 0) w = c;
        end
        if (w < 0) begin
          cmp("grant_without_request", 1, 0);
        end else begin
          m_rd   = (p_rv & oh(w)) != 0;
          m_addr = m_rd ? raddr(w) : waddr(w);
          m_wd   = wdata(w);
          m_cur  = w;
          m_busy = 1'b1;
          g_addr = m_rd ? mra : mwa;
          g_wd   = mwd;
          cmp("grant_kind", {mrv, mwv}, {m_rd, !m_rd});
          cmp("grant_addr", g_addr, m_addr);
          if (!m_rd) cmp("grant_wdata", mwd, m_wd);
        end
      end else begin
        if (mrv) cmp("rd_addr_stable", mra, m_addr);
        if (mwv) cmp("wr_addr_stable", mwa, m_addr);
        if (mwv) cmp("wr_data_stable", mwd, m_wd);
      end
      if (p_mrv) cmp("mem_rd_valid_hold", mrv, !p_mrr);
      if (p_mwv) cmp("mem_wr_valid_hold", mwv, !p_mwr);
      oh_cur = oh(m_cur);
      er = (m_busy && m_rd && p_mrv && p_mrr) ? oh_cur : '0;
      ew = (m_busy && !m_rd && p_mwv && p_mwr) ? oh_cur : '0;
      cmp("rd_ready_rise", crr & ~p_crr, er);
      cmp("wr_ready_rise", cwr & ~p_cwr, ew);
      if (er != 0) begin
        exp_rdata[m_cur] = mem_model[m_addr];
        m_busy = 1'b0; m_ptr = (m_cur + 1) % N; done_q.push_back(m_cur);
      end
      if (ew != 0) begin
        m_busy = 1'b0; m_ptr = (m_cur + 1) % N; done_q.push_back(16 + m_cur);
      end
      cmp("ready_owner", (crr | cwr) & ~oh_cur, 0);
      pk = '0;
      for (int k = 0; k < N; k++) pk = pk | (RDW'(exp_rdata[k]) << (k * DW));
      cmp("rdata_hold", crd, pk);
    end
  endtask

  task automatic memory();
    if (mrr) begin
      mrr = 1'b0; rd_cnt = 0;
    end else if (mrv && mem_auto) begin
      rd_cnt++;
      if (rd_cnt >= lat) begin mrr = 1'b1; mrd = mem_model[mra]; end
    end
    if (mwr) begin
      mwr = 1'b0; wr_cnt = 0;
    end else if (mwv && mem_auto) begin
      wr_cnt++;
      if (wr_cnt >= lat) begin mwr = 1'b1; mem_model[mwa] = mwd; end
    end
  endtask

  // LSU stand-ins drop valid as soon as they see ready, unless told to hold.
  task automatic lsu();
    for (int i = 0; i < N; i++) begin
      if ((crr & oh(i)) != 0) begin
        if (hold[i] > 0) hold[i]--; else crv = crv & ~oh(i);
      end
      if ((cwr & oh(i)) != 0) cwv = cwv & ~oh(i);
    end
  endtask

  task automatic tick();
    p_rv = crv; p_wv = cwv; p_crr = crr; p_cwr = cwr;
    p_mrv = mrv; p_mwv = mwv; p_mrr = mrr; p_mwr = mwr; p_rst = reset;
    @(posedge clk);
    #1;
    check();
    memory();
    lsu();
  endtask

  task automatic run_until(input int n, input int budget, input string name, output int used);
    used = 0;
    while (done_q.size() < n && used < budget) begin
      tick();
      used++;
    end
    cmp(name, done_q.size(), n);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int  used, hi, regrant;
    bit  rer;
    reset = 1'b1;
    crv = '0; cwv = '0; cra = '0; cwa = '0; cwd = '0;
    mrr = 1'b0; mwr = 1'b0; mrd = '0;
    for (int a = 0; a < 256; a++) mem_model[a] = 32'h5A5A_0000 + 32'(a);
    mem_model[8'h10] = 32'hDEAD_BEEF;
    for (int i = 0; i < N; i++) hold[i] = 0;
    idle(2);
    reset = 1'b0;
    idle(2);

    // Single read by consumer 2
    done_q.delete();
    set_read(2, 8'h10);
    run_until(1, 40, "read_done", used);
    cmp("read_latency", used, 4);
    cmp("read_mem_addr", g_addr, 8'h10);
    cmp("read_data_c2", DW'(crd >> (2 * DW)), 32'hDEAD_BEEF);
    tick();
    cmp("read_pulse_width", crr, 0);
    idle(2);

    // Single write by consumer 5
    done_q.delete();
    rd_seen = 1'b0;
    set_write(5, 8'h20, 32'h0000_1234);
    run_until(1, 40, "write_done", used);
    cmp("write_id", get_done(0), 21);
    cmp("write_mem_addr", g_addr, 8'h20);
    cmp("write_mem_data", g_wd, 32'h0000_1234);
    cmp("write_no_read", rd_seen, 0);
    tick();
    cmp("write_pulse_width", cwr, 0);
    idle(2);

    // Fairness from rr_ptr=0, with consumer 0 re-requesting after its grant
    reset = 1'b1; tick(); reset = 1'b0; tick();
    done_q.delete();
    set_read(0, 8'h30); set_read(3, 8'h33); set_read(7, 8'h37);
    rer = 1'b0; used = 0;
    while (done_q.size() < 4 && used < 200) begin
      tick(); used++;
      if (done_q.size() == 1 && !rer && (crr & oh(0)) == 0) begin
        set_read(0, 8'h31); rer = 1'b1;
      end
    end
    cmp("fair_count", done_q.size(), 4);
    cmp("fair_order0", get_done(0), 0);
    cmp("fair_order1", get_done(1), 3);
    cmp("fair_order2", get_done(2), 7);
    cmp("fair_order3", get_done(3), 0);
    cmp("fair_data_c0", DW'(crd), 32'h5A5A_0031);
    cmp("fair_data_c7", DW'(crd >> (7 * DW)), 32'h5A5A_0037);
    idle(2);

    // Consumer 1 holds read_valid two cycles past ready
    done_q.delete();
    hold[1] = 2;
    set_read(1, 8'h12);
    run_until(1, 40, "held_done", used);
    hi = 1; regrant = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if ((crr & oh(1)) != 0) hi++;
      if (mrv || mwv) regrant++;
    end
    cmp("held_ready_width", hi, 3);
    cmp("held_no_regrant", regrant, 0);

    // Wrap-around: serve consumer 6 so rr_ptr=7, then 7 and 0 together
    done_q.delete();
    set_write(6, 8'h26, 32'h0000_0066);
    run_until(1, 40, "wrap_prep", used);
    idle(2);
    done_q.delete();
    set_read(7, 8'h47); set_read(0, 8'h40);
    run_until(2, 80, "wrap_done", used);
    cmp("wrap_order0", get_done(0), 7);
    cmp("wrap_order1", get_done(1), 0);
    idle(2);

    // Read and write together from consumer 4: read first, write later
    done_q.delete();
    set_read(4, 8'h44); set_write(4, 8'h54, 32'h0000_ABCD);
    run_until(2, 80, "both_done", used);
    cmp("both_order0", get_done(0), 4);
    cmp("both_order1", get_done(1), 20);
    cmp("both_rdata_c4", DW'(crd >> (4 * DW)), 32'h5A5A_0044);
    cmp("both_wr_commit", mem_model[8'h54], 32'h0000_ABCD);
    idle(2);

    // Reset during READ_WAITING, then a late memory ready
    done_q.delete();
    mem_auto = 1'b0;
    set_read(3, 8'h13);
    idle(3);
    cmp("midrst_pre_valid", mrv, 1);
    crv = '0;
    reset = 1'b1; tick(); reset = 1'b0;
    cmp("midrst_mrv", mrv, 0);
    mrr = 1'b1; mrd = 32'hFFFF_FFFF;
    idle(4);
    cmp("midrst_no_ready", crr, 0);
    cmp("midrst_no_done", done_q.size(), 0);
    mem_auto = 1'b1;

    // Spurious write ready while idle
    mwr = 1'b1;
    idle(3);
    cmp("spurious_wr_ready", cwr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
